// File: rtl/gf277_inverse.sv
// Fermat inverse in GF(277): a^275 mod 277 by MSB-first square-and-multiply,
// one Barrett-reduced modular multiply per clock.
module gf277_inverse (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] din_a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] dout_inv,
    output logic       dout_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SQR  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [8:0]  EXP   = 9'd275;
    localparam logic [8:0]  MOD9  = 9'd277;
    localparam logic [17:0] MOD18 = 18'd277;
    localparam logic [18:0] MU    = 19'd946;

    logic [1:0] state;
    logic [8:0] r;
    logic [8:0] a;
    logic [3:0] idx;

    logic [8:0]  mul_b;
    logic [16:0] prod;
    logic [8:0]  q_est;
    logic [17:0] rem0;
    logic [17:0] rem1;
    logic [17:0] rem2;
    logic [8:0]  mul_res;
    logic        last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_step = (idx == 4'd0);

    // Barrett estimate undershoots the true quotient by at most two.
    always_comb begin
        mul_b   = (state == MUL) ? a : r;
        prod    = {8'b0, r} * {8'b0, mul_b};
        q_est   = 9'((19'(prod[16:8]) * MU) >> 10);
        rem0    = {1'b0, prod} - 18'(q_est) * MOD18;
        rem1    = (rem0 >= MOD18) ? rem0 - MOD18 : rem0;
        rem2    = (rem1 >= MOD18) ? rem1 - MOD18 : rem1;
        mul_res = 9'(rem2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= 9'd0;
            a         <= 9'd0;
            idx       <= 4'd0;
            dout_inv  <= 9'd0;
            dout_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a     <= (din_a >= MOD9) ? din_a - MOD9 : din_a;
                        r     <= 9'd1;
                        idx   <= 4'd8;
                        state <= SQR;
                    end
                end
                SQR: begin
                    r <= mul_res;
                    if (EXP[idx]) begin
                        state <= MUL;
                    end else if (last_step) begin
                        state     <= DONE;
                        dout_inv  <= mul_res;
                        dout_zero <= (a == 9'd0);
                    end else begin
                        idx <= idx - 4'd1;
                    end
                end
                MUL: begin
                    r <= mul_res;
                    if (last_step) begin
                        state     <= DONE;
                        dout_inv  <= mul_res;
                        dout_zero <= (a == 9'd0);
                    end else begin
                        idx   <= idx - 4'd1;
                        state <= SQR;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf277_inverse.sv
// Bench for gf277_inverse: exponentiation model, per-cycle output compare,
// directed vectors and a full operand sweep.
module tb_gf277_inverse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] din_a = 9'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] dout_inv;
    logic       dout_zero;

    gf277_inverse dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .din_a(din_a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout_inv(dout_inv),
        .dout_zero(dout_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int inv;
        int zero;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   acc_log[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   done_cnt = 0;
    int   last_inv = -1;
    int   last_zero = -1;
    bit   first = 1'b1;

    function automatic int ref_inv(input int x);
        int av = x % 277;
        int rv = 1;
        for (int i = 0; i < 275; i++) rv = (rv * av) % 277;
        return rv;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Acceptance monitor: pre-edge values decide whether the edge accepts.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back('{ref_inv(int'(din_a)),
                              ((int'(din_a) % 277) == 0) ? 1 : 0, cyc});
            acc_log.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            first = 1'b1;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_dout_inv", int'(dout_inv), 0);
            chk("rst_dout_zero", int'(dout_zero), 0);
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("dout_inv", int'(dout_inv), exp_q[0].inv);
                chk("dout_zero", int'(dout_zero), exp_q[0].zero);
                if (first) chk("latency", cyc - exp_q[0].acc, 13);
                first = 1'b0;
                if (out_ready) begin
                    last_inv  = int'(dout_inv);
                    last_zero = int'(dout_zero);
                    void'(exp_q.pop_front());
                    done_cnt++;
                    first = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n0);
        for (int i = 0; i < 40 && acc_log.size() == n0; i++) tick();
        chk("accepted", int'(acc_log.size() != n0), 1);
    endtask

    task automatic send(input int x);
        int n0;
        n0 = acc_log.size();
        in_valid = 1'b1;
        din_a = 9'(x);
        wait_acc(n0);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 60 && done_cnt < target; i++) tick();
        chk("done", int'(done_cnt >= target), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int c0;
        chk("model_2", ref_inv(2), 139);
        chk("model_3", ref_inv(3), 185);
        chk("model_276", ref_inv(276), 276);
        chk("model_279", ref_inv(279), 139);
        chk("model_5", ref_inv(5), 111);
        chk("model_277", ref_inv(277), 0);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(2);
        wait_done(done_cnt + 1);
        chk("inv_2", last_inv, 139);
        chk("zero_2", last_zero, 0);

        n0 = acc_log.size();
        c0 = done_cnt;
        in_valid = 1'b1;
        din_a = 9'd1;
        wait_acc(n0);
        din_a = 9'd3;
        wait_acc(n0 + 1);
        din_a = 9'd276;
        wait_acc(n0 + 2);
        in_valid = 1'b0;
        wait_done(c0 + 3);
        chk("b2b_gap1", acc_log[n0 + 1] - acc_log[n0], 15);
        chk("b2b_gap2", acc_log[n0 + 2] - acc_log[n0 + 1], 15);
        chk("inv_276", last_inv, 276);

        send(279);
        wait_done(done_cnt + 1);
        chk("inv_279", last_inv, 139);
        send(277);
        wait_done(done_cnt + 1);
        chk("inv_277", last_inv, 0);
        chk("zero_277", last_zero, 1);

        out_ready = 1'b0;
        send(7);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        chk("hold_reached", int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", int'(in_ready), 1);
        chk("inv_7", last_inv, 198);

        send(9);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_dout_inv", int'(dout_inv), 0);
        chk("abort_dout_zero", int'(dout_zero), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_pulse", int'(out_valid), 0);
        end
        c0 = cyc;
        send(5);
        chk("accept_after_reset", acc_log[acc_log.size() - 1] - c0, 1);
        wait_done(done_cnt + 1);
        chk("inv_5", last_inv, 111);

        for (int x = 0; x < 512; x++) begin
            send(x);
            wait_done(done_cnt + 1);
            if ((x % 277) != 0) begin
                chk("sweep_product", ((x % 277) * last_inv) % 277, 1);
                chk("sweep_zero", last_zero, 0);
            end else begin
                chk("sweep_zero_inv", last_inv, 0);
                chk("sweep_zero_flag", last_zero, 1);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gf277_inverse.md
GF277_INVERSE -- requirements
Module: gf277_inverse

Interface
REQ-001 The block SHALL have no parameters; modulus q = 277 and exponent e = q-2 = 275 (binary 1_0001_0011) SHALL be fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  din_a holds an operand.
REQ-005 in_ready  output  1  block is able to accept an operand.
REQ-006 din_a  input  9  operand; any value 0..511 is legal.
REQ-007 out_valid  output  1  dout_inv and dout_zero hold a result.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 dout_inv  output  9  multiplicative inverse of the operand mod 277, in the range 0..276.
REQ-010 dout_zero  output  1  the reduced operand was 0, which has no inverse.

Function
REQ-011 The block SHALL compute dout_inv = a^275 mod 277 (Fermat inverse), where a = din_a mod 277.
REQ-012 On acceptance, a SHALL be formed as din_a - 277 if din_a >= 277, else din_a; one subtraction is sufficient for din_a <= 511.
REQ-013 The FSM SHALL have states IDLE, SQR, MUL, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL occur on a clk edge where in_valid && in_ready; at that edge a is registered, accumulator r <= 1, bit index <= 8, and state <= SQR.
REQ-016 SQR: r <= r*r mod 277; if exponent bit[index] = 1, next state is MUL; else index decrements and state stays SQR.
REQ-017 MUL: r <= r*a mod 277, then index decrements and state returns to SQR.
REQ-018 Processing the step at index 0 SHALL move the FSM to DONE instead of decrementing the index.
REQ-019 Exactly one modular multiply per cycle; 9 SQR plus 4 MUL gives 13 compute cycles.
REQ-020 out_valid SHALL first be 1 in the cycle after the 13th compute edge, i.e. 13 clocks after the acceptance edge; latency is independent of the operand value.
REQ-021 The modular multiply SHALL form a 17-bit product (max 276*276 = 76176) and reduce it exactly to 0..276.
REQ-022 Reduction SHALL use Barrett with k = 9 and mu = 946, followed by as many conditional subtractions of 277 as needed for an exact result.
REQ-023 In DONE, out_valid = 1, and dout_inv and dout_zero SHALL be held stable until out_valid && out_ready.
REQ-024 On the edge where out_valid && out_ready, state <= IDLE, so in_ready = 1 in the next cycle.
REQ-025 No new operand SHALL be accepted in the same cycle as result handoff (minimum 15-cycle issue interval).
REQ-026 When a = 0, the block SHALL still take the full latency, with dout_inv = 0 and dout_zero = 1.
REQ-027 dout_zero SHALL be 0 for every nonzero a.
REQ-028 dout_inv and dout_zero SHALL be driven from registers, with no combinational path from any input.
REQ-029 in_valid asserted while busy SHALL be ignored and SHALL NOT corrupt the computation.
REQ-030 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-031 While rst_n = 0: state = IDLE, in_ready = 1, out_valid = 0, dout_inv = 0, dout_zero = 0, r = 0, a = 0, index = 0.
REQ-032 Reset asserted mid-computation or in DONE SHALL abort immediately and discard the result; no out_valid pulse follows.
REQ-033 After rst_n deasserts, the first rising edge with in_valid = 1 SHALL accept an operand.

Verification
REQ-034 din_a = 2, out_ready = 1 -> out_valid 13 clocks after acceptance, dout_inv = 139, dout_zero = 0.
REQ-035 Back-to-back operands 1, 3, 276 with in_valid held high -> results 1, 185, 276 in order; each acceptance is 15 clocks after the previous one.
REQ-036 din_a = 279 -> dout_inv = 139; din_a = 277 -> dout_inv = 0, dout_zero = 1.
REQ-037 out_ready held 0 for 20 cycles after out_valid -> dout_inv stable, in_ready = 0 throughout; one cycle after out_ready = 1 is seen, in_ready = 1.
REQ-038 rst_n pulsed low at compute cycle 6 -> outputs take reset values immediately; no out_valid pulse follows; next operand 5 -> dout_inv = 111.
REQ-039 Exhaustive sweep din_a = 0..511 -> for every nonzero a, (a * dout_inv) mod 277 = 1, and latency is always 13 clocks.
